// File: rtl/div_pkg.sv
// Shared types and constants for the divided-clock measurement blocks.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        TRACK,
        LOCKED,
        LOST
    } meas_state_e;

    localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/div_sync_edge.sv
// Synchronizes an asynchronous level into clk and flags its rising/falling edges.
module div_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic d_sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign d_sync = sync_q[SYNC_STAGES-1];
    assign rise   = d_sync & ~dly_q;
    assign fall   = ~d_sync & dly_q;

endmodule

// File: rtl/div_ratio_meas.sv
// Measures period and high time of a slow/divided clock, tracks lock and loss.
module div_ratio_meas
    import div_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             locked,
    output logic             ratio_err,
    output logic             lost
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_LAST = 4'(LOCK_CNT - 1);

    meas_state_e      state_q;
    logic [3:0]       match_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, high_q;
    logic             vld_q, locked_q, err_q, lost_q;
    logic             s_sync, rise, sync_fall_unused;
    logic             timeout, same;

    div_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_async(div_in),
        .d_sync (s_sync),
        .rise   (rise),
        .fall   (sync_fall_unused)
    );

    // A rise in the same cycle as the timeout always wins.
    assign timeout = (cnt_q == TMO) && !rise;
    assign same    = (cnt_q == period_q);

    always_comb begin
        cnt_d  = cnt_q;
        hcnt_d = hcnt_q;
        if (!en || state_q == IDLE) begin
            cnt_d  = '0;
            hcnt_d = '0;
        end else if (rise) begin
            cnt_d  = CNT_W'(1);
            hcnt_d = CNT_W'(1);
        end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            if (s_sync && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            hcnt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hcnt_q <= hcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            match_q  <= '0;
            period_q <= '0;
            high_q   <= '0;
            vld_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            if (!en) begin
                state_q  <= IDLE;
                match_q  <= '0;
                locked_q <= 1'b0;
                lost_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: state_q <= ARMED;
                    ARMED, LOST: begin
                        if (rise) begin
                            state_q <= TRACK;
                            match_q <= '0;
                            lost_q  <= 1'b0;
                        end else if (timeout && state_q == ARMED) begin
                            state_q <= LOST;
                            lost_q  <= 1'b1;
                        end
                    end
                    TRACK: begin
                        if (rise) begin
                            period_q <= cnt_q;
                            high_q   <= hcnt_q;
                            vld_q    <= 1'b1;
                            if (!same) begin
                                match_q <= '0;
                            end else if (match_q == LOCK_LAST) begin
                                match_q  <= match_q + 4'd1;
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                match_q <= match_q + 4'd1;
                            end
                        end else if (timeout) begin
                            state_q <= LOST;
                            lost_q  <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (rise) begin
                            period_q <= cnt_q;
                            high_q   <= hcnt_q;
                            vld_q    <= 1'b1;
                            if (!same) begin
                                err_q    <= 1'b1;
                                locked_q <= 1'b0;
                                match_q  <= '0;
                                state_q  <= TRACK;
                            end
                        end else if (timeout) begin
                            state_q  <= LOST;
                            lost_q   <= 1'b1;
                            locked_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign period_vld = vld_q;
    assign locked     = locked_q;
    assign ratio_err  = err_q;
    assign lost       = lost_q;

endmodule
